// File: rtl/blowfish_core.sv
// Blowfish block engine: P[0] whitening, ROUNDS Feistel rounds, final whitening.
// S-boxes and P-array live outside; this block only issues single-port reads.
module blowfish_core #(
   parameter int ROUNDS = 16,
   parameter int P_AW   = $clog2(ROUNDS + 2)
) (
   input  logic            clk,
   input  logic            reset_l,
   input  logic            start,
   input  logic            decrypt,
   input  logic [31:0]     xl_in,
   input  logic [31:0]     xr_in,
   output logic            busy,
   output logic            done,
   output logic [31:0]     xl_out,
   output logic [31:0]     xr_out,
   output logic            s_rd_en,
   output logic [9:0]      s_addr,
   input  logic [31:0]     s_data,
   output logic            p_rd_en,
   output logic [P_AW-1:0] p_addr,
   input  logic [31:0]     p_data
);

   localparam int R_W = $clog2(ROUNDS + 1);
   localparam logic [P_AW-1:0] P_LAST = P_AW'(ROUNDS + 1);
   localparam logic [R_W-1:0]  R_LAST = R_W'(ROUNDS);

   generate
      if ((ROUNDS < 2) || (ROUNDS % 2 != 0)) begin : g_bad_rounds
         $error("blowfish_core: ROUNDS must be even and >= 2");
      end
   endgenerate

   typedef enum logic [3:0] {
      IDLE, INIT_RD, INIT_CAP, RD0, RD1, RD2, RD3, RDP, MIX, FIN_RD, FIN_CAP, DONE
   } state_t;

   state_t          state_reg;
   logic            dec_reg;
   logic [31:0]     xl_in_reg, xr_in_reg;
   logic [31:0]     xl_reg, xr_reg, acc_reg;
   logic [31:0]     xl_out_reg, xr_out_reg;
   logic [R_W-1:0]  rnd_reg;
   logic            busy_reg, done_reg;

   logic [31:0]     src;
   logic [P_AW-1:0] p_k;

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign xl_out = xl_out_reg;
   assign xr_out = xr_out_reg;

   // Odd rounds read Xl and modify Xr; even rounds the reverse (no swap needed).
   always_comb begin
      src     = rnd_reg[0] ? xl_reg : xr_reg;
      s_rd_en = 1'b0;
      s_addr  = '0;
      p_rd_en = 1'b0;
      p_k     = '0;
      case (state_reg)
         INIT_RD: p_rd_en = 1'b1;
         RD0: begin
            s_rd_en = 1'b1;
            s_addr  = {2'd0, src[31:24]};
         end
         RD1: begin
            s_rd_en = 1'b1;
            s_addr  = {2'd1, src[23:16]};
         end
         RD2: begin
            s_rd_en = 1'b1;
            s_addr  = {2'd2, src[15:8]};
         end
         RD3: begin
            s_rd_en = 1'b1;
            s_addr  = {2'd3, src[7:0]};
         end
         RDP: begin
            p_rd_en = 1'b1;
            p_k     = P_AW'(rnd_reg);
         end
         FIN_RD: begin
            p_rd_en = 1'b1;
            p_k     = P_LAST;
         end
         default: ;
      endcase
      // Decryption walks the P-array backwards.
      p_addr = (p_rd_en && dec_reg) ? (P_LAST - p_k) : p_k;
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_reg  <= IDLE;
         dec_reg    <= 1'b0;
         xl_in_reg  <= '0;
         xr_in_reg  <= '0;
         xl_reg     <= '0;
         xr_reg     <= '0;
         acc_reg    <= '0;
         xl_out_reg <= '0;
         xr_out_reg <= '0;
         rnd_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  dec_reg   <= decrypt;
                  xl_in_reg <= xl_in;
                  xr_in_reg <= xr_in;
                  busy_reg  <= 1'b1;
                  state_reg <= INIT_RD;
               end
            end
            INIT_RD: state_reg <= INIT_CAP;
            INIT_CAP: begin
               xl_reg    <= xl_in_reg ^ p_data;
               xr_reg    <= xr_in_reg;
               rnd_reg   <= R_W'(1);
               state_reg <= RD0;
            end
            RD0: state_reg <= RD1;
            RD1: begin
               acc_reg   <= s_data;
               state_reg <= RD2;
            end
            RD2: begin
               acc_reg   <= acc_reg + s_data;
               state_reg <= RD3;
            end
            RD3: begin
               acc_reg   <= acc_reg ^ s_data;
               state_reg <= RDP;
            end
            RDP: begin
               acc_reg   <= acc_reg + s_data;
               state_reg <= MIX;
            end
            MIX: begin
               if (rnd_reg[0]) xr_reg <= xr_reg ^ acc_reg ^ p_data;
               else            xl_reg <= xl_reg ^ acc_reg ^ p_data;
               if (rnd_reg == R_LAST) begin
                  state_reg <= FIN_RD;
               end else begin
                  rnd_reg   <= rnd_reg + R_W'(1);
                  state_reg <= RD0;
               end
            end
            FIN_RD: state_reg <= FIN_CAP;
            FIN_CAP: begin
               xl_out_reg <= xr_reg ^ p_data;
               xr_out_reg <= xl_reg;
               done_reg   <= 1'b1;
               state_reg  <= DONE;
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blowfish_core.sv
// Directed bench for blowfish_core: ROUNDS=16 main instance plus a ROUNDS=4 instance,
// both served by a registered-read S/P memory model and a result scoreboard.
module tb_blowfish_core;

   localparam int R = 16;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_l, start, decrypt;
   logic [31:0] xl_in, xr_in;
   logic        busy, done, s_rd_en, p_rd_en;
   logic [31:0] xl_out, xr_out;
   logic [9:0]  s_addr;
   logic [4:0]  p_addr;
   logic [31:0] s_data = '0, p_data = '0;

   logic        start4, decrypt4;
   logic [31:0] xl_in4, xr_in4;
   logic        busy4, done4, s_rd_en4, p_rd_en4;
   logic [31:0] xl_out4, xr_out4;
   logic [9:0]  s_addr4;
   logic [2:0]  p_addr4;
   logic [31:0] s_data4 = '0, p_data4 = '0;

   blowfish_core #(.ROUNDS(R)) dut (
      .clk(clk), .reset_l(reset_l), .start(start), .decrypt(decrypt),
      .xl_in(xl_in), .xr_in(xr_in), .busy(busy), .done(done),
      .xl_out(xl_out), .xr_out(xr_out), .s_rd_en(s_rd_en), .s_addr(s_addr),
      .s_data(s_data), .p_rd_en(p_rd_en), .p_addr(p_addr), .p_data(p_data)
   );

   blowfish_core #(.ROUNDS(4)) dut4 (
      .clk(clk), .reset_l(reset_l), .start(start4), .decrypt(decrypt4),
      .xl_in(xl_in4), .xr_in(xr_in4), .busy(busy4), .done(done4),
      .xl_out(xl_out4), .xr_out(xr_out4), .s_rd_en(s_rd_en4), .s_addr(s_addr4),
      .s_data(s_data4), .p_rd_en(p_rd_en4), .p_addr(p_addr4), .p_data(p_data4)
   );

   logic [31:0] sbox [0:1023];
   logic [31:0] parr [0:17];

   always @(posedge clk) begin
      if (s_rd_en)  s_data  <= sbox[s_addr];
      if (p_rd_en)  p_data  <= parr[p_addr];
      if (s_rd_en4) s_data4 <= sbox[s_addr4];
      if (p_rd_en4) p_data4 <= parr[{2'b00, p_addr4}];
   end

   typedef struct packed {
      logic [31:0] xl;
      logic [31:0] xr;
   } res_t;
   res_t exp_q[$];

   int compared   = 0;
   int mismatched = 0;

   logic [9:0]  s_log  [0:255];
   logic [4:0]  pa_log [0:255];
   logic        pen_log[0:255];
   logic [4:0]  plog   [0:31];
   int          nplog;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] xl, input logic [31:0] xr,
                                         input bit dec, input int rounds);
      logic [31:0] l, r, f, src;
      int idx;
      l = xl ^ parr[dec ? rounds + 1 : 0];
      r = xr;
      for (int i = 1; i <= rounds; i++) begin
         src = (i % 2 == 1) ? l : r;
         f = ((sbox[{2'd0, src[31:24]}] + sbox[{2'd1, src[23:16]}]) ^ sbox[{2'd2, src[15:8]}])
             + sbox[{2'd3, src[7:0]}];
         idx = dec ? rounds + 1 - i : i;
         if (i % 2 == 1) r = r ^ f ^ parr[idx];
         else            l = l ^ f ^ parr[idx];
      end
      idx = dec ? 0 : rounds + 1;
      return {r ^ parr[idx], l};
   endfunction

   // Cycle 0 is the cycle start is high; sampling is at each falling edge.
   task automatic run_op(input logic [31:0] xl, input logic [31:0] xr, input bit dec,
                         input int inj_cyc, input bit inj_done,
                         output int done_cyc, output int n_s, output int n_p);
      logic [63:0] m;
      res_t e;
      int cyc, bad_busy;
      m = model(xl, xr, dec, R);
      exp_q.push_back(res_t'(m));
      @(negedge clk);
      xl_in = xl; xr_in = xr; decrypt = dec; start = 1'b1;
      @(negedge clk);
      start = 1'b0; xl_in = ~xl; xr_in = ~xr; decrypt = ~dec;
      cyc = 1; done_cyc = -1; n_s = 0; n_p = 0; nplog = 0; bad_busy = 0;
      while (cyc < 200) begin
         s_log[cyc] = s_addr; pa_log[cyc] = p_addr; pen_log[cyc] = p_rd_en;
         if (s_rd_en) n_s++;
         if (p_rd_en) begin
            if (nplog < 32) plog[nplog] = p_addr;
            nplog++;
            n_p++;
         end
         if (busy !== 1'b1) bad_busy++;
         start = (cyc == inj_cyc) || ((done === 1'b1) && inj_done);
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check("busy_during", 64'(bad_busy), 64'd0);
      check("done_seen", 64'(done), 64'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("xl_out", 64'(xl_out), 64'(e.xl));
         check("xr_out", 64'(xr_out), 64'(e.xr));
      end
      @(negedge clk);
      start = 1'b0;
      check("post_ctrl", 64'({busy, done, s_rd_en, p_rd_en}), 64'd0);
      @(negedge clk);
      check("post_idle", 64'({busy, done}), 64'd0);
      $display("op xl=%h xr=%h dec=%0d -> xl_out=%h xr_out=%h done_cyc=%0d s_rd=%0d p_rd=%0d",
               xl, xr, dec, xl_out, xr_out, done_cyc, n_s, n_p);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, ns, np, cyc, bad, dc4;
      logic [63:0] m;
      res_t e;

      reset_l = 1'b0; start = 1'b0; decrypt = 1'b0; xl_in = '0; xr_in = '0;
      start4 = 1'b0; decrypt4 = 1'b0; xl_in4 = '0; xr_in4 = '0;
      for (int i = 0; i < 1024; i++) sbox[i] = '0;
      for (int k = 0; k < 18; k++) parr[k] = 32'(k);

      repeat (3) @(negedge clk);
      check("rst_out", {xl_out, xr_out}, 64'd0);
      check("rst_ctrl", 64'({busy, done, s_rd_en, p_rd_en, s_addr, p_addr}), 64'd0);
      reset_l = 1'b1;
      @(negedge clk);

      // All-zero S, P[k]=k: F is zero so the result is a pure XOR of P words.
      run_op(32'h0, 32'h0, 1'b0, -1, 1'b0, dc, ns, np);
      check("t1_xl_const", 64'(xl_out), 64'h11);
      check("t1_xr_const", 64'(xr_out), 64'h10);
      check("t1_done_cyc", 64'(dc), 64'd101);
      check("t1_s_reads", 64'(ns), 64'd64);
      check("t1_p_reads", 64'(np), 64'd18);

      run_op(32'h12345678, 32'h0, 1'b0, -1, 1'b0, dc, ns, np);
      check("t2_s_addr0", 64'(s_log[3]), 64'h012);
      check("t2_s_addr1", 64'(s_log[4]), 64'h134);
      check("t2_s_addr2", 64'(s_log[5]), 64'h256);
      check("t2_s_addr3", 64'(s_log[6]), 64'h378);
      check("t2_p_en",    64'(pen_log[7]), 64'd1);
      check("t2_p_addr",  64'(pa_log[7]), 64'd1);

      // Extra starts mid-round and in the DONE cycle must be ignored.
      run_op(32'h0, 32'h0, 1'b0, 50, 1'b1, dc, ns, np);
      check("t3_done_cyc", 64'(dc), 64'd101);
      check("t3_xl_const", 64'(xl_out), 64'h11);

      // Asynchronous reset in round 7.
      @(negedge clk);
      xl_in = 32'hdeadbeef; xr_in = 32'h1; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      check("rst_mid_active", 64'(s_rd_en), 64'd1);
      #2 reset_l = 1'b0;
      #1;
      check("rst_async_out", {xl_out, xr_out}, 64'd0);
      check("rst_async_ctrl", 64'({busy, done, s_rd_en, p_rd_en, s_addr, p_addr}), 64'd0);
      repeat (2) @(negedge clk);
      reset_l = 1'b1;
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (busy || done || s_rd_en || p_rd_en) bad++;
      end
      check("rst_no_done", 64'(bad), 64'd0);
      $display("reset mid-op: idle cycles with activity=%0d", bad);
      run_op(32'h5, 32'h7, 1'b0, -1, 1'b0, dc, ns, np);
      check("t4_done_cyc", 64'(dc), 64'd101);

      // ROUNDS=4 instance on the same trivial tables.
      m = model(32'h0, 32'h0, 1'b0, 4);
      exp_q.push_back(res_t'(m));
      @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      cyc = 1; dc4 = -1;
      while (cyc < 100) begin
         if (done4 === 1'b1) begin
            dc4 = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check("r4_done", 64'(done4), 64'd1);
      check("r4_done_cyc", 64'(dc4), 64'd29);
      e = exp_q.pop_front();
      check("r4_xl_out", 64'(xl_out4), 64'(e.xl));
      check("r4_xr_out", 64'(xr_out4), 64'(e.xr));
      check("r4_xr_const", 64'(xr_out4), 64'h6);
      $display("r4 op -> xl_out=%h xr_out=%h done_cyc=%0d", xl_out4, xr_out4, dc4);

      // Random key material: encrypt, then decrypt the model ciphertext.
      for (int i = 0; i < 1024; i++) sbox[i] = $urandom;
      for (int k = 0; k < 18; k++) parr[k] = $urandom;
      run_op(32'h0, 32'h1, 1'b0, -1, 1'b0, dc, ns, np);
      m = model(32'h0, 32'h1, 1'b0, R);
      run_op(m[63:32], m[31:0], 1'b1, -1, 1'b0, dc, ns, np);
      check("rt_xl", 64'(xl_out), 64'h0);
      check("rt_xr", 64'(xr_out), 64'h1);
      check("rt_p_reads", 64'(nplog), 64'd18);
      for (int i = 0; i < 18; i++) check("dec_p_order", 64'(plog[i]), 64'(17 - i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
